// File: rtl/lif_neuron_array_core.sv
// Leaky integrate-and-fire neuron with a serially loaded parameter set.
// Define LIF_SPIKE_STATS_EN to build the saturating spike counter.
module lif_neuron_array_core #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 3,
  parameter int W_W    = 3,
  parameter int V_W    = 8,
  parameter int REF_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_CH*IN_W-1:0] chan_in,
  input  logic                   load_mode,
  input  logic                   serial_data,
  input  logic                   clear_stats,
  output logic                   spike_out,
  output logic [V_W-1:0]         v_mem_out,
  output logic                   params_ready,
  output logic [7:0]             spike_count
);

  localparam int CFG_BITS = NUM_CH*W_W + 2 + V_W + REF_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam int PROD_W   = IN_W + W_W;
  localparam int SUM_W    = V_W + PROD_W + 4;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);
  localparam logic [SUM_W-1:0] V_MAX    = SUM_W'({V_W{1'b1}});

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_SHIFT,
    LD_COMMIT
  } ld_state_t;

  typedef enum logic [1:0] {
    N_WAIT,
    N_INTEG,
    N_REFRACT
  } n_state_t;

  ld_state_t           r_ld_state;
  logic [CFG_BITS-1:0] r_shift;
  logic [CFG_BITS-1:0] r_act;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_ready;

  n_state_t            r_n_state;
  logic [V_W-1:0]      r_v;
  logic [REF_W-1:0]    r_ref_cnt;
  logic                r_spike;

  logic [1:0]          w_leak_cfg;
  logic [V_W-1:0]      w_thr;
  logic [REF_W-1:0]    w_refrac;
  logic [V_W-1:0]      w_leak;
  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W-1:0]    w_total;
  logic [V_W-1:0]      w_v_next;
  logic                w_fire;

  assign w_leak_cfg = r_act[V_W+REF_W +: 2];
  assign w_thr      = r_act[REF_W +: V_W];
  assign w_refrac   = r_act[0 +: REF_W];

  // Frame shifts in MSB first, so w0 ends up in the top bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_state <= LD_IDLE;
      r_shift    <= '0;
      r_act      <= '0;
      r_bit_cnt  <= '0;
      r_ready    <= 1'b0;
    end else if (enable) begin
      unique case (r_ld_state)
        LD_IDLE: begin
          if (load_mode) begin
            r_shift    <= {r_shift[CFG_BITS-2:0], serial_data};
            r_bit_cnt  <= CNT_W'(1);
            r_ld_state <= LD_SHIFT;
          end
        end
        LD_SHIFT: begin
          if (!load_mode) begin
            r_bit_cnt  <= '0;
            r_ld_state <= LD_IDLE;
          end else begin
            r_shift   <= {r_shift[CFG_BITS-2:0], serial_data};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
              r_ld_state <= LD_COMMIT;
            end
          end
        end
        LD_COMMIT: begin
          r_act      <= r_shift;
          r_ready    <= 1'b1;
          r_bit_cnt  <= '0;
          r_ld_state <= LD_IDLE;
        end
        default: begin
          r_ld_state <= LD_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = w_sum
            + SUM_W'(chan_in[i*IN_W +: IN_W])
            * SUM_W'(r_act[CFG_BITS-1-i*W_W -: W_W]);
    end
  end

  always_comb begin
    w_leak = '0;
    unique case (w_leak_cfg)
      2'd0: w_leak = '0;
      2'd1: w_leak = r_v >> 3;
      2'd2: w_leak = r_v >> 2;
      2'd3: w_leak = r_v >> 1;
      default: w_leak = '0;
    endcase
  end

  // Leak never exceeds v, so the subtraction cannot wrap.
  assign w_total  = SUM_W'(r_v) - SUM_W'(w_leak) + w_sum;
  assign w_v_next = (w_total > V_MAX) ? {V_W{1'b1}} : w_total[V_W-1:0];
  assign w_fire   = (w_v_next >= w_thr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n_state <= N_WAIT;
      r_v       <= '0;
      r_ref_cnt <= '0;
      r_spike   <= 1'b0;
    end else if (!enable) begin
      r_spike <= 1'b0;
    end else begin
      r_spike <= 1'b0;
      unique case (r_n_state)
        N_WAIT: begin
          r_v <= '0;
          if (r_ready) begin
            r_n_state <= N_INTEG;
          end
        end
        N_INTEG: begin
          if (w_fire) begin
            r_spike <= 1'b1;
            r_v     <= '0;
            if (w_refrac != '0) begin
              r_ref_cnt <= w_refrac;
              r_n_state <= N_REFRACT;
            end
          end else begin
            r_v <= w_v_next;
          end
        end
        N_REFRACT: begin
          r_v <= '0;
          if (r_ref_cnt <= REF_W'(1)) begin
            r_ref_cnt <= '0;
            r_n_state <= N_INTEG;
          end else begin
            r_ref_cnt <= r_ref_cnt - REF_W'(1);
          end
        end
        default: begin
          r_n_state <= N_WAIT;
        end
      endcase
    end
  end

`ifdef LIF_SPIKE_STATS_EN
  logic [7:0] r_spike_cnt;
  logic       w_int_fire;

  assign w_int_fire = (r_n_state == N_INTEG) && w_fire;

  // Clear takes priority over a coincident spike.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spike_cnt <= '0;
    end else if (enable) begin
      if (clear_stats) begin
        r_spike_cnt <= '0;
      end else if (w_int_fire && (r_spike_cnt != 8'hFF)) begin
        r_spike_cnt <= r_spike_cnt + 8'd1;
      end
    end
  end

  assign spike_count = r_spike_cnt;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_stats;
  assign spike_count    = 8'd0;
`endif

  assign spike_out    = r_spike;
  assign v_mem_out    = r_v;
  assign params_ready = r_ready;

endmodule

// File: tb/tb_lif_neuron_array_core.sv
// Directed bench for lif_neuron_array_core at default parameters.
// Spike counter expectations follow LIF_SPIKE_STATS_EN.
module tb_lif_neuron_array_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] chan_in = '0;
  logic        load_mode = 1'b0;
  logic        serial_data = 1'b0;
  logic        clear_stats = 1'b0;
  logic        spike_out;
  logic [7:0]  v_mem_out;
  logic        params_ready;
  logic [7:0]  spike_count;

  int n_pass = 0;
  int n_chk  = 0;

  lif_neuron_array_core dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .chan_in      (chan_in),
    .load_mode    (load_mode),
    .serial_data  (serial_data),
    .clear_stats  (clear_stats),
    .spike_out    (spike_out),
    .v_mem_out    (v_mem_out),
    .params_ready (params_ready),
    .spike_count  (spike_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] mkf(
    input logic [2:0] w0, input logic [2:0] w1,
    input logic [2:0] w2, input logic [2:0] w3,
    input logic [1:0] lk, input logic [7:0] thr,
    input logic [3:0] rf);
    return {w0, w1, w2, w3, lk, thr, rf};
  endfunction

  // Sends the top nbits of a frame, then drops load_mode for one edge.
  task automatic send_frame(input logic [25:0] f, input int nbits);
    load_mode = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      serial_data = f[25-i];
      tick();
    end
    load_mode   = 1'b0;
    serial_data = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; load_mode = 1'b0;
    clear_stats = 1'b0; chan_in = '0; serial_data = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_chk++; if (spike_out !== 1'b0) $display("FAIL rst_spike got %0b want 0", spike_out); else n_pass++;
    n_chk++; if (v_mem_out !== 8'd0) $display("FAIL rst_v got %0d want 0", v_mem_out); else n_pass++;
    n_chk++; if (params_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", params_ready); else n_pass++;
    n_chk++; if (spike_count !== 8'd0) $display("FAIL rst_count got %0d want 0", spike_count); else n_pass++;
  endtask

  task automatic test_integrate();
    do_reset();
    send_frame(mkf(3'd1, 3'd1, 3'd1, 3'd1, 2'd0, 8'd20, 4'd2), 26);
    n_chk++; if (params_ready !== 1'b1) $display("FAIL int_ready got %0b want 1", params_ready); else n_pass++;
    tick();
    n_chk++; if (v_mem_out !== 8'd0) $display("FAIL int_v0 got %0d want 0", v_mem_out); else n_pass++;
    chan_in = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_chk++; if (v_mem_out !== 8'(4*k)) $display("FAIL int_v%0d got %0d want %0d", k, v_mem_out, 4*k); else n_pass++;
      n_chk++; if (spike_out !== 1'b0) $display("FAIL int_nospike%0d got %0b want 0", k, spike_out); else n_pass++;
    end
    tick();
    n_chk++; if (spike_out !== 1'b1) $display("FAIL int_spike got %0b want 1", spike_out); else n_pass++;
    n_chk++; if (v_mem_out !== 8'd0) $display("FAIL int_spike_v got %0d want 0", v_mem_out); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++; if (v_mem_out !== 8'd0) $display("FAIL ref_v%0d got %0d want 0", k, v_mem_out); else n_pass++;
      n_chk++; if (spike_out !== 1'b0) $display("FAIL ref_spike%0d got %0b want 0", k, spike_out); else n_pass++;
    end
    tick();
    n_chk++; if (v_mem_out !== 8'd4) $display("FAIL resume_v got %0d want 4", v_mem_out); else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    send_frame(mkf(3'd7, 3'd7, 3'd7, 3'd7, 2'd0, 8'd255, 4'd0), 26);
    tick();
    chan_in = {3'd7, 3'd7, 3'd7, 3'd7};
    tick();
    n_chk++; if (v_mem_out !== 8'd196) $display("FAIL sat_v1 got %0d want 196", v_mem_out); else n_pass++;
    n_chk++; if (spike_out !== 1'b0) $display("FAIL sat_nospike got %0b want 0", spike_out); else n_pass++;
    tick();
    n_chk++; if (spike_out !== 1'b1) $display("FAIL sat_spike got %0b want 1", spike_out); else n_pass++;
    n_chk++; if (v_mem_out !== 8'd0) $display("FAIL sat_v2 got %0d want 0", v_mem_out); else n_pass++;
    tick();
    n_chk++; if (v_mem_out !== 8'd196) $display("FAIL sat_norefrac got %0d want 196", v_mem_out); else n_pass++;
  endtask

  task automatic test_leak();
    logic [7:0] exp_v [8];
    exp_v = '{8'd49, 8'd25, 8'd13, 8'd7, 8'd4, 8'd2, 8'd1, 8'd1};
    do_reset();
    send_frame(mkf(3'd7, 3'd0, 3'd0, 3'd0, 2'd3, 8'd255, 4'd0), 26);
    tick();
    chan_in = 12'd7;
    for (int k = 0; k < 8; k++) begin
      tick();
      chan_in = '0;
      n_chk++; if (v_mem_out !== exp_v[k]) $display("FAIL leak_v%0d got %0d want %0d", k, v_mem_out, exp_v[k]); else n_pass++;
    end
  endtask

  task automatic test_abort();
    do_reset();
    send_frame(mkf(3'd1, 3'd1, 3'd1, 3'd1, 2'd0, 8'd20, 4'd2), 26);
    tick();
    send_frame(mkf(3'd7, 3'd7, 3'd7, 3'd7, 2'd0, 8'd255, 4'd0), 10);
    n_chk++; if (params_ready !== 1'b1) $display("FAIL abort_ready got %0b want 1", params_ready); else n_pass++;
    chan_in = {3'd1, 3'd1, 3'd1, 3'd1};
    tick();
    chan_in = '0;
    n_chk++; if (v_mem_out !== 8'd4) $display("FAIL abort_oldw got %0d want 4", v_mem_out); else n_pass++;
    send_frame(mkf(3'd7, 3'd7, 3'd7, 3'd7, 2'd0, 8'd255, 4'd0), 26);
    n_chk++; if (v_mem_out !== 8'd4) $display("FAIL reload_hold got %0d want 4", v_mem_out); else n_pass++;
    chan_in = {3'd7, 3'd7, 3'd7, 3'd7};
    tick();
    chan_in = '0;
    n_chk++; if (v_mem_out !== 8'd200) $display("FAIL reload_neww got %0d want 200", v_mem_out); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [25:0] f;
    f = mkf(3'd1, 3'd1, 3'd1, 3'd1, 2'd0, 8'd20, 4'd2);
    do_reset();
    send_frame(f, 26);
    tick();
    chan_in = {3'd1, 3'd1, 3'd1, 3'd1};
    tick();
    chan_in = '0;
    load_mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      serial_data = f[25-i];
      tick();
    end
    reset = 1'b1;
    load_mode = 1'b0;
    #1;
    n_chk++; if (v_mem_out !== 8'd0) $display("FAIL mid_v got %0d want 0", v_mem_out); else n_pass++;
    n_chk++; if (params_ready !== 1'b0) $display("FAIL mid_ready got %0b want 0", params_ready); else n_pass++;
    n_chk++; if (spike_out !== 1'b0) $display("FAIL mid_spike got %0b want 0", spike_out); else n_pass++;
    tick();
    reset = 1'b0;
    send_frame(f, 13);
    n_chk++; if (params_ready !== 1'b0) $display("FAIL mid_partial got %0b want 0", params_ready); else n_pass++;
    send_frame(f, 26);
    n_chk++; if (params_ready !== 1'b1) $display("FAIL mid_full got %0b want 1", params_ready); else n_pass++;
  endtask

  task automatic test_enable();
    do_reset();
    send_frame(mkf(3'd1, 3'd1, 3'd1, 3'd1, 2'd0, 8'd8, 4'd1), 26);
    tick();
    chan_in = {3'd1, 3'd1, 3'd1, 3'd1};
    tick();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_chk++; if (v_mem_out !== 8'd4) $display("FAIL en_hold got %0d want 4", v_mem_out); else n_pass++;
    enable = 1'b1;
    tick();
    n_chk++; if (spike_out !== 1'b1) $display("FAIL en_spike got %0b want 1", spike_out); else n_pass++;
    enable = 1'b0;
    tick();
    n_chk++; if (spike_out !== 1'b0) $display("FAIL en_spike_off got %0b want 0", spike_out); else n_pass++;
    enable = 1'b1;
    tick();
    n_chk++; if (v_mem_out !== 8'd0) $display("FAIL en_refrac got %0d want 0", v_mem_out); else n_pass++;
    tick();
    n_chk++; if (v_mem_out !== 8'd4) $display("FAIL en_resume got %0d want 4", v_mem_out); else n_pass++;
  endtask

  task automatic test_stats();
    logic [7:0] e1, e255, e0b;
`ifdef LIF_SPIKE_STATS_EN
    e1 = 8'd1; e255 = 8'd255; e0b = 8'd1;
`else
    e1 = 8'd0; e255 = 8'd0; e0b = 8'd0;
`endif
    do_reset();
    send_frame(mkf(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'd0, 4'd0), 26);
    tick();
    tick();
    n_chk++; if (spike_count !== e1) $display("FAIL st_one got %0d want %0d", spike_count, e1); else n_pass++;
    for (int k = 2; k <= 255; k++) tick();
    n_chk++; if (spike_count !== e255) $display("FAIL st_255 got %0d want %0d", spike_count, e255); else n_pass++;
    tick();
    n_chk++; if (spike_count !== e255) $display("FAIL st_sat got %0d want %0d", spike_count, e255); else n_pass++;
    n_chk++; if (spike_out !== 1'b1) $display("FAIL st_spike got %0b want 1", spike_out); else n_pass++;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    n_chk++; if (spike_count !== 8'd0) $display("FAIL st_clear got %0d want 0", spike_count); else n_pass++;
    tick();
    n_chk++; if (spike_count !== e0b) $display("FAIL st_after got %0d want %0d", spike_count, e0b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_saturate();
    test_leak();
    test_abort();
    test_reset_midframe();
    test_enable();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
